// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch requester, loader requester, memory port.
// Latency: n/a (signal bundle only).
// Backpressure: fetch sees fetch_stall; the loader sees ldr_gnt.
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              ldr_req;
  logic              ldr_we;
  logic              ldr_lock;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_done;
  logic [DATA_W-1:0] ldr_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_addr, ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, mem_rdata,
    output fetch_stall, fetch_valid, fetch_data, ldr_gnt, ldr_done, ldr_rdata,
           mem_addr, mem_we, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output fetch_req, fetch_addr, ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, mem_rdata,
    input  fetch_stall, fetch_valid, fetch_data, ldr_gnt, ldr_done, ldr_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-ported instruction memory between fetch (default owner) and the loader.
// Latency: grant decode is combinational; read data returns 1 cycle after grant.
// Backpressure: fetch held via fetch_stall; loader waits on ldr_gnt (at most MAX_WAIT+1 cycles).
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH_OWN = 2'd0,
    LDR_OWN   = 2'd1,
    LDR_LOCK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LDR_RD = 2'd2,
    OWN_LDR_WR = 2'd3
  } owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              ldr_gnt_c;
  logic              fetch_gnt_c;
  logic              stall_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  // State, starvation counter and return-path owner tag; reset drops any in-flight tag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH_OWN;
      owner    <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Grant decode, next state, wait counter and memory port steering
  always_comb begin
    state_nxt   = state;
    ldr_gnt_c   = 1'b0;
    fetch_gnt_c = 1'b0;
    stall_c     = 1'b0;
    wait_nxt    = wait_cnt;
    owner_nxt   = OWN_NONE;

    case (state)
      LDR_LOCK: begin
        // Burst: loader keeps the port while it requests; fetch held including the idle exit cycle
        stall_c   = bus.fetch_req;
        ldr_gnt_c = bus.ldr_req;
        if (!bus.ldr_req) state_nxt = FETCH_OWN;
      end
      default: begin
        // FETCH_OWN; the single-access loader state never persists past its grant cycle
        state_nxt = FETCH_OWN;
        if (bus.ldr_req && (!bus.fetch_req || wait_cnt == WAIT_MAX)) begin
          ldr_gnt_c = 1'b1;
          stall_c   = bus.fetch_req;
          if (bus.ldr_lock) state_nxt = LDR_LOCK;
        end else if (bus.fetch_req) begin
          fetch_gnt_c = 1'b1;
        end
      end
    endcase

    if (ldr_gnt_c || !bus.ldr_req) begin
      wait_nxt = '0;
    end else if (fetch_gnt_c && wait_cnt < WAIT_MAX) begin
      wait_nxt = wait_cnt + 4'd1;
    end

    // Nothing is granted while reset is held, so outputs stay quiet
    if (!reset) begin
      ldr_gnt_c   = 1'b0;
      fetch_gnt_c = 1'b0;
      stall_c     = 1'b0;
    end

    if (ldr_gnt_c) begin
      owner_nxt = bus.ldr_we ? OWN_LDR_WR : OWN_LDR_RD;
    end else if (fetch_gnt_c) begin
      owner_nxt = OWN_FETCH;
    end

    addr_c  = ldr_gnt_c ? bus.ldr_addr : bus.fetch_addr;
    we_c    = ldr_gnt_c & bus.ldr_we;
    wdata_c = ldr_gnt_c ? bus.ldr_wdata : '0;
  end

  assign bus.ldr_gnt     = ldr_gnt_c;
  assign bus.fetch_stall = stall_c;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_we      = we_c;
  assign bus.mem_wdata   = wdata_c;

  assign bus.fetch_valid = (owner == OWN_FETCH);
  assign bus.ldr_done    = (owner == OWN_LDR_RD) || (owner == OWN_LDR_WR);
  assign bus.fetch_data  = (owner == OWN_FETCH)  ? bus.mem_rdata : '0;
  assign bus.ldr_rdata   = (owner == OWN_LDR_RD) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 64-word synchronous memory model.
// Latency: checks comb decode in the grant cycle and return data one cycle later.
// Backpressure: exercises fetch stalls, the starvation bound and locked bursts.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory: word i initialised to 0xA0000000+i, 1-cycle read latency
  logic [31:0] rom [0:63];
  initial begin
    for (int k = 0; k < 64; k++) rom[k] = 32'hA000_0000 + k;
  end
  always @(posedge clk) begin
    if (bus.mem_we) rom[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= rom[bus.mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int done_cnt;
    int valid_cnt;
    int j;
    reset         = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h0;
    bus.ldr_req   = 1'b0;
    bus.ldr_we    = 1'b0;
    bus.ldr_lock  = 1'b0;
    bus.ldr_addr  = 32'h0;
    bus.ldr_wdata = 32'h0;

    // Reset held two cycles with fetch requesting: everything quiet
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
      chk("rst_ldr_done",    {31'b0, bus.ldr_done},    32'd0);
      chk("rst_ldr_gnt",     {31'b0, bus.ldr_gnt},     32'd0);
      chk("rst_fetch_stall", {31'b0, bus.fetch_stall}, 32'd0);
      chk("rst_mem_we",      {31'b0, bus.mem_we},      32'd0);
      chk("rst_mem_addr",    bus.mem_addr,             32'd0);
      chk("rst_fetch_data",  bus.fetch_data,           32'd0);
    end

    // First fetch after release
    cyc();
    reset = 1'b1;
    bus.fetch_addr = 32'h0040_0000;
    settle();
    chk("rel_mem_addr",    bus.mem_addr,             32'h0040_0000);
    chk("rel_fetch_stall", {31'b0, bus.fetch_stall}, 32'd0);
    chk("rel_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    cyc();
    bus.fetch_req = 1'b0;
    settle();
    chk("rel_valid1", {31'b0, bus.fetch_valid}, 32'd1);
    chk("rel_data",   bus.fetch_data,           32'hA000_0000);

    // Fetch-only stream of three words
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.fetch_req  = (i < 3);
      bus.fetch_addr = 32'h0040_0000 + 32'(4 * i);
      settle();
      if (i < 3) chk("str_stall", {31'b0, bus.fetch_stall}, 32'd0);
      if (i > 0) begin
        chk("str_valid", {31'b0, bus.fetch_valid}, 32'd1);
        chk("str_data",  bus.fetch_data,           32'hA000_0000 + 32'(i - 1));
      end
    end
    cyc(); settle();
    chk("str_valid_end", {31'b0, bus.fetch_valid}, 32'd0);

    // Starvation bound: four fetch grants then the loader read
    bus.ldr_req  = 1'b1;
    bus.ldr_we   = 1'b0;
    bus.ldr_addr = 32'h0040_0010;
    for (int i = 0; i < 5; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0040_0000 + 32'(4 * i);
      settle();
      chk("stv_gnt",   {31'b0, bus.ldr_gnt},     {31'b0, (i == 4)});
      chk("stv_stall", {31'b0, bus.fetch_stall}, {31'b0, (i == 4)});
      chk("stv_addr",  bus.mem_addr, (i == 4) ? 32'h0040_0010 : 32'h0040_0000 + 32'(4 * i));
      if (i > 0) chk("stv_fdata", bus.fetch_data, 32'hA000_0000 + 32'(i - 1));
      cyc();
    end
    bus.ldr_req    = 1'b0;
    bus.fetch_addr = 32'h0040_0014;
    settle();
    chk("stv_done",   {31'b0, bus.ldr_done},    32'd1);
    chk("stv_rdata",  bus.ldr_rdata,            32'hA000_0004);
    chk("stv_fvalid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("stv_resume", {31'b0, bus.fetch_stall}, 32'd0);
    cyc();
    bus.fetch_req = 1'b0;
    settle();
    chk("stv_fdata2", bus.fetch_data, 32'hA000_0005);
    chk("stv_done2",  {31'b0, bus.ldr_done}, 32'd0);

    // Loader write while fetch idle, then fetch the same word
    cyc();
    bus.ldr_req   = 1'b1;
    bus.ldr_we    = 1'b1;
    bus.ldr_addr  = 32'h0040_0008;
    bus.ldr_wdata = 32'h3400_0000;
    settle();
    chk("wr_gnt",   {31'b0, bus.ldr_gnt},     32'd1);
    chk("wr_we",    {31'b0, bus.mem_we},      32'd1);
    chk("wr_wdata", bus.mem_wdata,            32'h3400_0000);
    chk("wr_stall", {31'b0, bus.fetch_stall}, 32'd0);
    cyc();
    bus.ldr_req    = 1'b0;
    bus.ldr_we     = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0040_0008;
    settle();
    chk("wr_done",   {31'b0, bus.ldr_done},    32'd1);
    chk("wr_fvalid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("wr_we_off", {31'b0, bus.mem_we},      32'd0);
    cyc();
    bus.fetch_req = 1'b0;
    settle();
    chk("wr_rb_valid", {31'b0, bus.fetch_valid}, 32'd1);
    chk("wr_rb_data",  bus.fetch_data,           32'h3400_0000);

    // Locked burst of three writes behind four fetch grants; lock dropped mid-burst
    done_cnt  = 0;
    valid_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      j = (i > 4) ? i - 4 : 0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0040_0040;
      bus.ldr_req    = (i < 7);
      bus.ldr_we     = 1'b1;
      bus.ldr_lock   = (i < 5);
      bus.ldr_addr   = 32'h0040_0020 + 32'(4 * j);
      bus.ldr_wdata  = 32'h11 * 32'(j + 1);
      settle();
      chk("bst_gnt",   {31'b0, bus.ldr_gnt},     {31'b0, (i >= 4 && i <= 6)});
      chk("bst_stall", {31'b0, bus.fetch_stall}, {31'b0, (i >= 4 && i <= 7)});
      if (i >= 5) begin
        done_cnt  += int'(bus.ldr_done);
        valid_cnt += int'(bus.fetch_valid);
      end
    end
    chk("bst_done_cnt",  32'(done_cnt),  32'd3);
    chk("bst_valid_cnt", 32'(valid_cnt), 32'd0);
    cyc();
    bus.fetch_addr = 32'h0040_0024;
    settle();
    chk("bst_fdata", bus.fetch_data, 32'hA000_0010);
    cyc();
    bus.fetch_req = 1'b0;
    settle();
    chk("bst_rb", bus.fetch_data, 32'h0000_0022);

    // Reset landing on the edge after a loader read grant
    cyc();
    bus.ldr_req  = 1'b1;
    bus.ldr_we   = 1'b0;
    bus.ldr_lock = 1'b1;
    bus.ldr_addr = 32'h0040_0010;
    settle();
    chk("mra_gnt", {31'b0, bus.ldr_gnt}, 32'd1);
    #1;
    reset = 1'b0;
    cyc();
    bus.ldr_req = 1'b0;
    settle();
    chk("mra_done",   {31'b0, bus.ldr_done},    32'd0);
    chk("mra_fvalid", {31'b0, bus.fetch_valid}, 32'd0);
    cyc();
    reset          = 1'b1;
    bus.ldr_req    = 1'b1;
    bus.ldr_lock   = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0040_0000;
    settle();
    chk("mra_done2", {31'b0, bus.ldr_done},    32'd0);
    chk("mra_gnt2",  {31'b0, bus.ldr_gnt},     32'd0);
    chk("mra_stall", {31'b0, bus.fetch_stall}, 32'd0);
    chk("mra_addr",  bus.mem_addr,             32'h0040_0000);
    cyc();
    bus.ldr_req   = 1'b0;
    bus.fetch_req = 1'b0;
    settle();
    chk("mra_fdata", bus.fetch_data, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for the single-ported instruction memory, sharing it between the fetch stage and a program loader/debug port. Fetch owns the port by default. Loader accesses are granted on demand, with a bounded wait. The block drives the memory address/write controls, routes read data back to the owner of each access, and produces the stall that gates the PC register enable while fetch is denied.

## Interface
- ADDR_W, 32, address width for both requesters and memory
- DATA_W, 32, data width
- MAX_WAIT, 4, maximum consecutive fetch grants while a loader request is pending (1..15)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- fetch_req  in  1  fetch wants an instruction read this cycle
- fetch_addr  in  ADDR_W  fetch byte address (PC)
- fetch_stall  out  1  fetch denied this cycle; PC must hold
- fetch_valid  out  1  fetch_data valid (read granted previous cycle)
- fetch_data  out  DATA_W  instruction word
- ldr_req  in  1  loader access request
- ldr_we  in  1  1 = write, 0 = read
- ldr_lock  in  1  keep ownership while ldr_req stays high (burst)
- ldr_addr  in  ADDR_W  loader byte address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  loader owns the port this cycle
- ldr_done  out  1  loader access granted previous cycle completed
- ldr_rdata  out  DATA_W  loader read data (valid with ldr_done for reads)
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency

## Operation
- States: FETCH_OWN (default), LDR_OWN (single loader access), LDR_LOCK (loader burst).
- FETCH_OWN, per cycle:
  - Loader is granted when ldr_req=1 and either fetch_req=0 or wait_cnt==MAX_WAIT.
  - Otherwise fetch is granted when fetch_req=1.
  - If neither requester is asserted, the port is idle.
- wait_cnt (4 bits):
  - Increments on each fetch grant while ldr_req=1.
  - Clears on every loader grant and whenever ldr_req=0.
  - Saturates at MAX_WAIT.
- Loader grant:
  - ldr_gnt=1 and fetch_stall=fetch_req.
  - mem_addr=ldr_addr.
  - mem_we=ldr_we.
  - mem_wdata=ldr_wdata.
  - Next state is LDR_LOCK if ldr_lock=1, else FETCH_OWN.
- LDR_LOCK:
  - The loader is granted every cycle that ldr_req=1. Fetch is stalled throughout and wait_cnt is ignored.
  - When ldr_req=0, the port is idle and the block returns to FETCH_OWN the next cycle. Fetch is stalled during that idle cycle if fetch_req=1.
- Fetch grant:
  - mem_addr=fetch_addr.
  - mem_we=0.
  - fetch_stall=0.
- Ungranted cycles:
  - mem_we=0.
  - mem_addr holds the fetch_addr value.
- Return path:
  - A registered owner tag (NONE/FETCH/LDR_RD/LDR_WR) is captured at grant.
  - The next cycle asserts exactly one of fetch_valid or ldr_done.
  - fetch_data=mem_rdata. ldr_rdata=mem_rdata for reads.
- Loader writes never produce fetch_valid. Write-then-read to the same address returns the new data.

## Timing
- Reset (reset=0 at a clock edge):
  - State becomes FETCH_OWN, wait_cnt=0, owner tag=NONE.
  - fetch_valid=0, ldr_done=0, ldr_gnt=0, mem_we=0.
  - fetch_stall=0 for the cycle after reset.
- Reset mid-access: the outstanding owner tag is discarded. No fetch_valid or ldr_done is asserted for it.
- Grant decode (ldr_gnt, fetch_stall, mem_*) is combinational from inputs and state, in the same cycle as the request.
- Read latency is 1 cycle: grant at cycle N gives fetch_valid/ldr_done at N+1.
- Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle.
- Simultaneous fetch_req and ldr_req with wait_cnt<MAX_WAIT: fetch wins.
- Worst-case loader latency from request to grant is MAX_WAIT+1 cycles.
- ldr_lock is sampled only on the granting cycle in FETCH_OWN. Dropping ldr_lock while in LDR_LOCK has no effect; only ldr_req ends the burst.

## Test plan
- Reset: hold reset=0 for 2 cycles with fetch_req=1 -> all outputs 0. After release, fetch_addr=0x00400000 gives mem_addr=0x00400000 and fetch_valid=1 one cycle later with the ROM word.
- Fetch-only stream: addresses 0x00400000, +4, +8 on consecutive cycles -> three consecutive fetch_valid pulses in order, fetch_stall=0 throughout.
- Starvation bound, MAX_WAIT=4: fetch_req and ldr_req held high (read, ldr_addr=0x00400010) -> 4 fetch grants, then ldr_gnt=1 and fetch_stall=1 in cycle 5, ldr_done=1 in cycle 6, then fetch resumes.
- Loader write then fetch: write 0x34000000 to 0x00400008 while fetch is idle -> ldr_done next cycle; a subsequent fetch at 0x00400008 returns 0x34000000.
- Locked burst: ldr_lock=1 with 3 writes -> fetch_stall=1 for 3 grant cycles plus 1 idle cycle, 3 ldr_done pulses, 0 fetch_valid pulses.
- Reset mid-access: loader read granted at cycle N, reset=0 at edge N+1 -> ldr_done stays 0, state FETCH_OWN.
